// File: rtl/cmd_pkg.sv
// Shared command-interface definitions: command codes, serializer states and
// frame sizing used by both the response serializer and the frame decoder.
package cmd_pkg;

  localparam logic [7:0] CMD_READ  = 8'ha0;
  localparam logic [7:0] CMD_WRITE = 8'h0a;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A frame is command word + address word + value words.
  function automatic int frame_width(input int word_width, input int value_words);
    return word_width * (value_words + 2);
  endfunction

endpackage

// File: rtl/response_serializer.sv
// Captures a C-A-V..V response frame on i_start and streams it out one word
// per valid/ready handshake, most-significant word first.
module response_serializer
  import cmd_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int VALUE_WORDS = 4
) (
  input  logic                              clk,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic [WORD_WIDTH-1:0]             i_cmd,
  input  logic [WORD_WIDTH-1:0]             i_addr,
  input  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_value,
  output logic [WORD_WIDTH-1:0]             o_data,
  output logic                              o_dv,
  input  logic                              i_ready,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_overrun
);

  localparam int FW = frame_width(WORD_WIDTH, VALUE_WORDS);
  localparam int CW = $clog2(VALUE_WORDS + 3);
  localparam logic [CW-1:0] LOAD_COUNT = CW'(VALUE_WORDS + 2);

  state_t          r_state, w_state_next;
  logic [FW-1:0]   r_shift, w_shift_next;
  logic [CW-1:0]   r_count, w_count_next;
  logic            r_done, w_done_next;
  logic            r_overrun, w_overrun_next;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_count   <= w_count_next;
      r_done    <= w_done_next;
      r_overrun <= w_overrun_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_count_next   = r_count;
    w_done_next    = 1'b0;
    w_overrun_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_shift_next = {i_cmd, i_addr, i_value};
          w_count_next = LOAD_COUNT;
          w_state_next = SEND;
        end
      end
      SEND: begin
        // A start request here is dropped, even on the final accept.
        w_overrun_next = i_start;
        if (i_ready) begin
          w_shift_next = {r_shift[FW-WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
          w_count_next = r_count - CW'(1);
          if (r_count == CW'(1)) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_data    = r_shift[FW-1 -: WORD_WIDTH];
  assign o_dv      = (r_state == SEND);
  assign o_busy    = (r_state == SEND);
  assign o_done    = r_done;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_response_serializer.sv
// Directed bench for response_serializer: basic frame, backpressure, overrun,
// back-to-back frames, mid-frame reset and reset/start collision.
module tb_response_serializer;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_cmd = 8'h00;
  logic [7:0]  i_addr = 8'h00;
  logic [31:0] i_value = 32'h0;
  logic [7:0]  o_data;
  logic        o_dv;
  logic        i_ready = 1'b1;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [47:0] FRAME_A = 48'ha0_3c_de_ad_be_ef;
  localparam logic [47:0] FRAME_B = 48'h0a_01_00_00_00_01;

  always #5 clk = ~clk;

  response_serializer #(.WORD_WIDTH(8), .VALUE_WORDS(4)) dut (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_cmd     (i_cmd),
    .i_addr    (i_addr),
    .i_value   (i_value),
    .o_data    (o_data),
    .o_dv      (o_dv),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_overrun (o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] value);
    i_start = 1'b1;
    i_cmd   = cmd;
    i_addr  = addr;
    i_value = value;
    step();
    i_start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " dv"},      32'(o_dv),      32'd0);
    check({tag, " busy"},    32'(o_busy),    32'd0);
    check({tag, " data"},    32'(o_data),    32'd0);
    check({tag, " overrun"}, 32'(o_overrun), 32'd0);
  endtask

  // Streams one frame out of the DUT, optionally toggling ready 1,0,1,0...
  task automatic collect(input logic [47:0] frame, input bit toggle, input string tag);
    int         idx = 0;
    int         cyc = 0;
    logic       stalled = 1'b0;
    logic [7:0] held = 8'h00;
    while (idx < 6 && cyc < 40) begin
      if (stalled) check({tag, " hold"}, 32'(o_data), 32'(held));
      check({tag, " dv"}, 32'(o_dv), 32'd1);
      i_ready = toggle ? logic'(cyc % 2 == 0) : 1'b1;
      if (i_ready) begin
        $display("%s: accept word %0d = %02h", tag, idx, o_data);
        check($sformatf("%s w%0d", tag, idx), 32'(o_data), 32'(frame[47 - 8*idx -: 8]));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = o_data;
      end
      step();
      cyc++;
    end
    i_ready = 1'b1;
    check({tag, " word count"}, 32'(idx), 32'd6);
    check({tag, " done"}, 32'(o_done), 32'd1);
    check({tag, " dv after"}, 32'(o_dv), 32'd0);
    check({tag, " busy after"}, 32'(o_busy), 32'd0);
    check({tag, " data after"}, 32'(o_data), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_idle("reset");
    check("reset done", 32'(o_done), 32'd0);
    i_reset = 1'b0;
    step();

    // Basic frame with ready held high
    issue_start(8'ha0, 8'h3c, 32'hdeadbeef);
    check("basic busy", 32'(o_busy), 32'd1);
    collect(FRAME_A, 1'b0, "basic");
    step();
    check("basic done pulse", 32'(o_done), 32'd0);
    check("basic data zero", 32'(o_data), 32'd0);

    // Backpressure
    issue_start(8'ha0, 8'h3c, 32'hdeadbeef);
    collect(FRAME_A, 1'b1, "bp");
    step();

    // Overrun at 2nd word and again on the last-accept cycle
    issue_start(8'ha0, 8'h3c, 32'hdeadbeef);
    check("ovr w0", 32'(o_data), 32'h00a0);
    step();
    check("ovr w1", 32'(o_data), 32'h003c);
    issue_start(8'h0a, 8'h01, 32'h00000001);
    $display("overrun: start dropped while busy");
    check("ovr pulse", 32'(o_overrun), 32'd1);
    check("ovr w2", 32'(o_data), 32'h00de);
    step();
    check("ovr pulse end", 32'(o_overrun), 32'd0);
    check("ovr w3", 32'(o_data), 32'h00ad);
    step();
    check("ovr w4", 32'(o_data), 32'h00be);
    step();
    check("ovr w5", 32'(o_data), 32'h00ef);
    issue_start(8'h0a, 8'h01, 32'h00000001);
    check("ovr last done", 32'(o_done), 32'd1);
    check("ovr last pulse", 32'(o_overrun), 32'd1);
    check("ovr last dv", 32'(o_dv), 32'd0);
    step();
    check("ovr no 2nd frame", 32'(o_dv), 32'd0);
    check("ovr done end", 32'(o_done), 32'd0);

    // Back-to-back: start in the o_done cycle
    issue_start(8'ha0, 8'h3c, 32'hdeadbeef);
    collect(FRAME_A, 1'b0, "b2b first");
    issue_start(8'h0a, 8'h01, 32'h00000001);
    collect(FRAME_B, 1'b0, "b2b second");
    step();

    // Reset after the 3rd accept
    issue_start(8'ha0, 8'h3c, 32'hdeadbeef);
    step();
    step();
    step();
    check("rst mid w3", 32'(o_data), 32'h00ad);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    $display("reset mid-frame");
    check_idle("rst mid");
    check("rst mid done", 32'(o_done), 32'd0);
    step();
    check("rst mid done later", 32'(o_done), 32'd0);
    issue_start(8'ha0, 8'h3c, 32'hdeadbeef);
    collect(FRAME_A, 1'b0, "rst fresh");
    step();

    // Reset and start in the same cycle
    i_reset = 1'b1;
    issue_start(8'ha0, 8'h3c, 32'hdeadbeef);
    i_reset = 1'b0;
    $display("reset/start collision");
    check_idle("collide");
    check("collide done", 32'(o_done), 32'd0);
    step();
    check("collide dv later", 32'(o_dv), 32'd0);
    check("collide overrun later", 32'(o_overrun), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/response_serializer.md
# response_serializer

Serializes one register-access response frame (command word, address word, then `VALUE_WORDS` value words, most-significant word first) into a stream of `WORD_WIDTH`-bit words for the byte transmitter. It sits on the return path of the command interface. It is the transmit-side counterpart of the frame decoder that feeds the register file, so a read result goes back to the host in the same C-A-V…V layout the host sends. The block captures a whole frame on a start pulse and releases it one word per valid/ready handshake.

## Interface
Parameters:
- `WORD_WIDTH`, 8: bits per transmitted word.
- `VALUE_WORDS`, 4: number of value words per frame; frame length is `VALUE_WORDS+2` words.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  one-cycle request to send a frame; sampled only in IDLE.
- `i_cmd`  in  `WORD_WIDTH`  command word (0xa0 read, 0x0a write echoes).
- `i_addr`  in  `WORD_WIDTH`  address word.
- `i_value`  in  `WORD_WIDTH*VALUE_WORDS`  value; bits [top -: `WORD_WIDTH`] sent first.
- `o_data`  out  `WORD_WIDTH`  current word to transmitter.
- `o_dv`  out  1  `o_data` valid.
- `i_ready`  in  1  transmitter accepts `o_data` this cycle when `o_dv` is high.
- `o_busy`  out  1  frame in progress (state SEND).
- `o_done`  out  1  one-cycle pulse after the last word is accepted.
- `o_overrun`  out  1  one-cycle pulse: `i_start` arrived while busy and was dropped.

## Operation
- States: IDLE, SEND. Reset state IDLE.
- IDLE: on `i_start`, load shift register with {`i_cmd`, `i_addr`, `i_value`} and word counter = `VALUE_WORDS+2`, then go to SEND.
- SEND: `o_dv`=1, `o_data` = top word of shift register. On `o_dv && i_ready`: shift left by `WORD_WIDTH`, zero-fill, decrement counter. When counter goes 1→0, return to IDLE.
- `i_ready` low: hold `o_data`/`o_dv` unchanged; no timeout.
- `i_start` in SEND, including the cycle of the last accept: ignored; `o_overrun`=1 next cycle; frame in flight unaffected.
- Counter width: `$clog2(VALUE_WORDS+3)`; no wrap possible.
- `o_data` after a completed frame is 0 (zero-filled); it is never X.
- Reset values: `o_data`=0, `o_dv`=0, `o_busy`=0, `o_done`=0, `o_overrun`=0, counter=0, shift register=0.
- `i_reset` has priority over everything: mid-frame reset aborts the frame. `i_start` in the same cycle as `i_reset` is ignored; no `o_done` and no `o_overrun`.

## Timing
- `i_start` at cycle N (IDLE) gives `o_dv`=1, `o_busy`=1, `o_data`=cmd at N+1.
- With `i_ready` held high, the words are cmd, addr, V[top]…V[0] on consecutive cycles N+1…N+`VALUE_WORDS`+2. Throughput is 1 word/clk.
- Last accept at cycle M gives `o_dv`=0, `o_busy`=0, `o_done`=1 at M+1. A new `i_start` at M+1 is accepted, so the minimum gap between frames is one idle cycle.
- All outputs are registered; there is no combinational path from `i_ready` or `i_start` to any output.

## Structure
- Shared package `cmd_pkg`:
  - `CMD_READ`=8'ha0, `CMD_WRITE`=8'h0a.
  - state enum {IDLE, SEND}.
  - frame-width localparam function of `WORD_WIDTH`/`VALUE_WORDS`.
  - The frame decoder imports the same constants.
- Single module; no sub-module. The shift register and counter are inline.

## Test plan
- Basic frame: `i_start` with cmd=0xa0, addr=0x3c, value=0xdeadbeef, `i_ready`=1 → `o_data` a0,3c,de,ad,be,ef on 6 consecutive cycles; `o_done` pulse on cycle 7; `o_data`=0 afterward.
- Backpressure: same frame with `i_ready` toggling 1,0,1,0… → same 6-word order, each word held while `i_ready`=0, no duplicate or lost words, `o_done` after 6th accept.
- Overrun: `i_start` (cmd 0x0a) at 2nd word of an active frame → `o_overrun` pulse next cycle; original frame completes unchanged; no second frame sent.
- Back-to-back: second `i_start` (addr 0x01, value 0x00000001) in the cycle `o_done`=1 → second frame 0a,01,00,00,00,01 begins next cycle.
- Reset mid-frame: `i_reset` after 3rd accept → next cycle all outputs 0 with no `o_done`; a subsequent `i_start` sends a full fresh 6-word frame.
- Reset+start collision: `i_start` and `i_reset` in the same cycle → stays IDLE, `o_dv`=0, `o_overrun`=0.
